// File: rtl/dmem_bus_ctrl_if.sv
// SRAM-like data bus between the MEM-stage controller and data memory.
// The master side issues req/wr/size/addr/wdata/wstrb and receives
// addr_ok (request accepted), data_ok (completion) and rdata.
interface dmem_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        output data_wstrb,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        input  data_wstrb,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data-memory bus controller.
// Turns each MEM-stage load/store into one req/addr_ok/data_ok bus
// transaction, stalls the pipeline until it completes, and aligns and
// extends load data into a registered MEM_DMOut.
// Optional feature macro: DMEM_WBUF_EN -- stores retire at addr_ok and a
// one-deep write-buffer flag holds off the next access until the store's
// data_ok arrives.
module dmem_bus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                MEM_Valid,
    input  logic                MEM_ExceptHit,
    input  logic [31:0]         MEM_ALUOut,
    input  logic                MEM_LoadEn,
    input  logic [1:0]          MEM_LoadSize,
    input  logic                MEM_LoadUnsigned,
    input  logic [DATA_W-1:0]   MEM_SWData,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    dmem_bus_ctrl_if.master     bus,
    output logic [DATA_W-1:0]   MEM_DMOut,
    output logic                DMem_Stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bus size from store strobe popcount: 1 byte -> 0, 2 -> 1, 4 -> 2.
    function automatic logic [1:0] strb_to_size(input logic [3:0] strb);
        logic [2:0] cnt;
        logic [1:0] size;
        cnt = {2'b00, strb[0]} + {2'b00, strb[1]} + {2'b00, strb[2]} + {2'b00, strb[3]};
        case (cnt)
            3'd1:    size = 2'd0;
            3'd2:    size = 2'd1;
            default: size = 2'd2;
        endcase
        return size;
    endfunction

    // Bus size from the pipeline's load-size encoding (00 word, 01 half, 10 byte).
    function automatic logic [1:0] load_to_size(input logic [1:0] lsize);
        logic [1:0] size;
        case (lsize)
            2'b00:   size = 2'd2;
            2'b01:   size = 2'd1;
            2'b10:   size = 2'd0;
            default: size = 2'd2;
        endcase
        return size;
    endfunction

    // Select the addressed lane of the returned word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  lsize,
                                                 input logic        uns);
        logic [15:0] half;
        logic [7:0]  byte_v;
        logic [31:0] res;
        half = off[1] ? rdata[31:16] : rdata[15:0];
        case (off)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        case (lsize)
            2'b01:   res = {{16{~uns & half[15]}}, half};
            2'b10:   res = {{24{~uns & byte_v[7]}}, byte_v};
            default: res = rdata;
        endcase
        return res;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic                  req_r;
    logic                  wr_r;
    logic [1:0]            size_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [DATA_W-1:0]     wdata_r;
    logic [DATA_W/8-1:0]   wstrb_r;
    logic                  ld_r;
    logic [1:0]            ld_size_r;
    logic                  ld_uns_r;
    logic [DATA_W-1:0]     dmout_r;

    logic                  is_store_s;
    logic                  pending_s;
    logic                  wbuf_block_s;
    logic                  capture_s;
    logic                  load_done_s;
    logic                  stall_s;

    assign is_store_s  = (data_sram_wen != 4'd0);
    assign pending_s   = MEM_Valid & ~MEM_ExceptHit & (MEM_LoadEn | is_store_s);
    assign capture_s   = (state_r == ST_IDLE) & pending_s & ~wbuf_block_s;
    assign load_done_s = (state_r == ST_WAIT) & bus.data_data_ok & ld_r;

`ifdef DMEM_WBUF_EN
    logic wbuf_pending_r;

    // A data_ok in the same cycle releases the block so the capture can proceed.
    assign wbuf_block_s = wbuf_pending_r & ~bus.data_data_ok;

    // Track the one buffered store between its addr_ok and its data_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wbuf_pending_r <= 1'b0;
        end else if ((state_r == ST_REQ) && bus.data_addr_ok && wr_r) begin
            wbuf_pending_r <= 1'b1;
        end else if (bus.data_data_ok) begin
            wbuf_pending_r <= 1'b0;
        end else begin
            wbuf_pending_r <= wbuf_pending_r;
        end
    end
`else
    assign wbuf_block_s = 1'b0;
`endif

    // Next-state logic for the IDLE/REQ/WAIT/DONE transaction sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.data_addr_ok) begin
`ifdef DMEM_WBUF_EN
                    state_s = wr_r ? ST_DONE : ST_WAIT;
`else
                    state_s = ST_WAIT;
`endif
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.data_data_ok) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Pipeline stall: held while an access is waiting to start or in flight.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = pending_s;
            ST_REQ:  stall_s = 1'b1;
            ST_WAIT: stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // State register and registered bus request (high exactly while in REQ).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            req_r   <= (state_s == ST_REQ);
        end
    end

    // Capture the access in IDLE; the fields then stay frozen through REQ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_r      <= 1'b0;
            size_r    <= 2'd0;
            addr_r    <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            ld_r      <= 1'b0;
            ld_size_r <= 2'd0;
            ld_uns_r  <= 1'b0;
        end else if (capture_s) begin
            wr_r      <= is_store_s;
            size_r    <= is_store_s ? strb_to_size(data_sram_wen) : load_to_size(MEM_LoadSize);
            addr_r    <= MEM_ALUOut[ADDR_W-1:0];
            wdata_r   <= MEM_SWData;
            wstrb_r   <= data_sram_wen;
            ld_r      <= MEM_LoadEn & ~is_store_s;
            ld_size_r <= MEM_LoadSize;
            ld_uns_r  <= MEM_LoadUnsigned;
        end else begin
            wr_r      <= wr_r;
            size_r    <= size_r;
            addr_r    <= addr_r;
            wdata_r   <= wdata_r;
            wstrb_r   <= wstrb_r;
            ld_r      <= ld_r;
            ld_size_r <= ld_size_r;
            ld_uns_r  <= ld_uns_r;
        end
    end

    // Load result register: updated only on a load's data_ok, held otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dmout_r <= '0;
        end else if (load_done_s) begin
            dmout_r <= extract_load(bus.data_rdata, addr_r[1:0], ld_size_r, ld_uns_r);
        end else begin
            dmout_r <= dmout_r;
        end
    end

    assign bus.data_req   = req_r;
    assign bus.data_wr    = wr_r;
    assign bus.data_size  = size_r;
    assign bus.data_addr  = addr_r;
    assign bus.data_wdata = wdata_r;
    assign bus.data_wstrb = wstrb_r;
    assign MEM_DMOut      = dmout_r;
    assign DMem_Stall     = stall_s;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: a driver issues MEM-stage accesses and
// pushes expected bus requests and completions; a bus-slave process answers
// requests and checks them; a monitor checks MEM_DMOut and stall length at
// each completion. A word-array memory model supplies load data.
module tb_dmem_bus_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int ad;
        int dd;
    } dly_t;

    typedef struct {
        logic [31:0] dm;
        int          stall;
    } done_t;

`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_except = 1'b0;
    logic [31:0] mem_aluout = 32'd0;
    logic        mem_loaden = 1'b0;
    logic [1:0]  mem_loadsize = 2'd0;
    logic        mem_loaduns = 1'b0;
    logic [31:0] mem_swdata = 32'd0;
    logic [3:0]  mem_wen = 4'd0;
    logic [31:0] dm_out;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    req_t        exp_req_q[$];
    dly_t        dly_q[$];
    done_t       done_q[$];
    int          req_cyc_q[$];
    int          dok_cyc_q[$];
    logic [31:0] mem [16];
    logic [31:0] exp_dm = 32'd0;

    dmem_bus_ctrl_if bus ();

    dmem_bus_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .MEM_Valid        (mem_valid),
        .MEM_ExceptHit    (mem_except),
        .MEM_ALUOut       (mem_aluout),
        .MEM_LoadEn       (mem_loaden),
        .MEM_LoadSize     (mem_loadsize),
        .MEM_LoadUnsigned (mem_loaduns),
        .MEM_SWData       (mem_swdata),
        .data_sram_wen    (mem_wen),
        .bus              (bus),
        .MEM_DMOut        (dm_out),
        .DMem_Stall       (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference load result: shift the addressed field down, mask, extend.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] lsize, input logic uns);
        logic [31:0] v;
        int sh;
        if (lsize == 2'd1) begin
            sh = addr[1] ? 16 : 0;
            v  = (word >> sh) & 32'h0000_FFFF;
            if (!uns && v >= 32'h0000_8000) v = v - 32'h0001_0000;
        end else if (lsize == 2'd2) begin
            sh = 8 * int'(addr[1:0]);
            v  = (word >> sh) & 32'h0000_00FF;
            if (!uns && v >= 32'h0000_0080) v = v - 32'h0000_0100;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // exp_stall: -2 = derive from latencies, -1 = do not check, else exact.
    task automatic issue(input logic except, input logic loaden, input logic [1:0] lsize,
                         input logic uns, input logic [31:0] addr, input logic [31:0] swdata,
                         input logic [3:0] wen, input int ad, input int dd, input int exp_stall);
        req_t  r;
        done_t e;
        dly_t  d;
        logic  wr;
        logic  pend;
        int    cnt;
        wr   = (wen != 4'd0);
        pend = !except && (loaden || wr);
        if (pend) begin
            cnt = 0;
            for (int b = 0; b < 4; b++) if (wen[b]) cnt++;
            r.addr  = addr;
            r.wr    = wr;
            r.size  = wr ? ((cnt == 1) ? 2'd0 : (cnt == 2) ? 2'd1 : 2'd2) : 2'(2 - int'(lsize));
            r.wdata = swdata;
            r.wstrb = wen;
            exp_req_q.push_back(r);
            d.ad = ad;
            d.dd = dd;
            dly_q.push_back(d);
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (wen[b]) mem[addr[5:2]][8*b +: 8] = swdata[8*b +: 8];
            end else begin
                exp_dm = model_load(mem[addr[5:2]], addr, lsize, uns);
            end
        end
        if (exp_stall != -2)  e.stall = exp_stall;
        else if (!pend)       e.stall = 0;
        else if (WBUF)        e.stall = -1;
        else                  e.stall = 3 + ad + dd;
        e.dm = exp_dm;
        done_q.push_back(e);
        mem_valid    = 1'b1;
        mem_except   = except;
        mem_loaden   = loaden;
        mem_loadsize = lsize;
        mem_loaduns  = uns;
        mem_aluout   = addr;
        mem_swdata   = swdata;
        mem_wen      = wen;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #3;
            if (!stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: stall still %0b after 300 cycles, expected 0", stall);
        end
        @(posedge clk);
        #1;
        mem_valid  = 1'b0;
        mem_except = 1'b0;
        mem_loaden = 1'b0;
        mem_wen    = 4'd0;
    endtask

    task automatic access(input logic except, input logic loaden, input logic [1:0] lsize,
                          input logic uns, input logic [31:0] addr, input logic [31:0] swdata,
                          input logic [3:0] wen, input int ad, input int dd, input int exp_stall);
        issue(except, loaden, lsize, uns, addr, swdata, wen, ad, dd, exp_stall);
        wait_done();
    endtask

    // Bus slave: accept one request, check it, then complete it.
    task automatic serve();
        req_t snap;
        req_t exp;
        dly_t d;
        bit   have_exp;
        snap.addr  = bus.data_addr;
        snap.wr    = bus.data_wr;
        snap.size  = bus.data_size;
        snap.wdata = bus.data_wdata;
        snap.wstrb = bus.data_wstrb;
        req_cyc_q.push_back(cyc);
        have_exp = 1'b1;
        exp = snap;
        d.ad = 0;
        d.dd = 0;
        if (exp_req_q.size() == 0 || dly_q.size() == 0) begin
            have_exp = 1'b0;
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: data_req=1 at addr %h, expected no request", snap.addr);
        end else begin
            exp = exp_req_q.pop_front();
            d   = dly_q.pop_front();
        end
        repeat (d.ad) begin
            @(negedge clk);
            if (!resetn) return;
            check("req_stable",
                  {bus.data_req, bus.data_addr, bus.data_wr, bus.data_size, bus.data_wdata, bus.data_wstrb},
                  {1'b1, snap.addr, snap.wr, snap.size, snap.wdata, snap.wstrb});
        end
        bus.data_addr_ok = 1'b1;
        if (have_exp) begin
            check("req_addr",  72'(snap.addr),  72'(exp.addr));
            check("req_wr",    72'(snap.wr),    72'(exp.wr));
            check("req_size",  72'(snap.size),  72'(exp.size));
            check("req_wstrb", 72'(snap.wstrb), 72'(exp.wstrb));
            if (exp.wr) check("req_wdata", 72'(snap.wdata), 72'(exp.wdata));
        end
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        if (!resetn) return;
        repeat (d.dd) begin
            @(negedge clk);
            if (!resetn) return;
        end
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = snap.wr ? $urandom : mem[snap.addr[5:2]];
        dok_cyc_q.push_back(cyc);
    endtask

    initial begin
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            if (resetn && bus.data_req) serve();
        end
    end

    // Monitor: at each completion compare MEM_DMOut and the stall length.
    initial begin
        int    stall_cnt;
        done_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn) begin
                stall_cnt = 0;
            end else if (mem_valid) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    if (done_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: completion with no access outstanding");
                    end else begin
                        e = done_q.pop_front();
                        check("dmout", 72'(dm_out), 72'(e.dm));
                        if (e.stall >= 0) check("stall_cycles", 72'(stall_cnt), 72'(e.stall));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        int          off;
        int          ls;
        logic [31:0] addr;
        logic [3:0]  wen;

        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus", {bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata, bus.data_wstrb}, 72'd0);
        check("reset_dmout", 72'(dm_out), 72'd0);
        check("reset_stall", 72'(stall), 72'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // LB unsigned, immediate handshakes: 3 stall cycles.
        mem[0] = 32'h80FF_1234;
        access(1'b0, 1'b1, 2'b10, 1'b1, 32'h0000_1003, 32'd0, 4'd0, 0, 0, 3);
        // LH signed, addr_ok delayed 3 cycles.
        mem[0] = 32'hF00D_0000;
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 4'd0, 3, 0, 6);
        // SW: MEM_DMOut must keep the LH result.
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 0, 0, WBUF ? 2 : 3);
        // Exception suppresses the access.
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_1004, 32'd0, 4'd0, 0, 0, 0);
        #2;
        check("except_no_req", 72'(bus.data_req), 72'd0);
        wait_done();

        // SB with slow completion followed by LW.
        req_cyc_q.delete();
        dok_cyc_q.delete();
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_4001, 32'h0000_AB00, 4'b0010, 0, 4, WBUF ? 2 : 7);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_4000, 32'd0, 4'd0, 0, 0, WBUF ? 6 : 3);
        if (req_cyc_q.size() >= 2 && dok_cyc_q.size() >= 1) begin
            check("lw_req_after_store_dok", 72'(req_cyc_q[1] - dok_cyc_q[0]), WBUF ? 72'd1 : 72'd3);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL lw_req_after_store_dok: saw %0d requests and %0d completions, expected 2 and 1",
                     req_cyc_q.size(), dok_cyc_q.size());
        end

        // Reset while in WAIT.
        mem[1] = 32'hCAFE_F00D;
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_5004, 32'd0, 4'd0, 0, 0, -2);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_5004, 32'd0, 4'd0, 0, 10, -1);
        @(posedge clk);
        @(posedge clk);
        #3;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        #1;
        check("rst_wait_bus", {bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata, bus.data_wstrb}, 72'd0);
        check("rst_wait_dmout", 72'(dm_out), 72'd0);
        check("rst_wait_stall", 72'(stall), 72'd0);
        done_q.delete();
        exp_dm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_5004, 32'd0, 4'd0, 1, 1, 5);

        // Randomized mix.
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            ls   = $urandom_range(0, 2);
            off  = (ls == 0) ? 0 : (ls == 1) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
            addr = 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2) | 32'(off);
            wen  = (ls == 0) ? 4'hF : (ls == 1) ? (4'b0011 << off) : (4'b0001 << off);
            if (kind <= 3) begin
                access(1'b0, 1'b1, (ls == 0) ? 2'b00 : (ls == 1) ? 2'b01 : 2'b10, 1'($urandom_range(0, 1)),
                       addr, $urandom, 4'd0, $urandom_range(0, 3), $urandom_range(0, 3), -2);
            end else if (kind <= 6) begin
                access(1'b0, 1'b0, 2'b00, 1'b0, addr, $urandom, wen,
                       $urandom_range(0, 3), $urandom_range(0, 3), -2);
            end else if (kind == 7) begin
                access(1'b1, 1'($urandom_range(0, 1)), 2'b00, 1'b0, addr, $urandom,
                       ($urandom_range(0, 1) == 1) ? wen : 4'd0, 0, 0, -2);
            end else begin
                access(1'b0, 1'b0, 2'b00, 1'b0, addr, $urandom, 4'd0, 0, 0, -2);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (10) @(posedge clk);
        #1;
        check("leftover_req", 72'(exp_req_q.size()), 72'd0);
        check("leftover_done", 72'(done_q.size()), 72'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
